phase_freq_est: RTL and testbench
=================================

# phase_freq_est

Phase-difference frequency estimator that sits directly downstream of the CORDIC atan stage. It takes the per-sample phase in (-pi, pi) radians and produces the wrapped phase increment for each sample. It also produces a block-averaged frequency estimate over 2^AVG_LOG2 increments. Its output feeds carrier/frequency-offset correction logic.

## Interface
- PHASE_W, 10: phase width. Signed format: 1 sign bit, 2 integer bits, PHASE_W-3 fraction bits, in radians. This is the CORDIC atan output format.
- AVG_LOG2, 2: log2 of averaging length N. Legal range 1..8.

- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset; clears all state.
- phase_valid_i  in  1  phase_i holds a new sample this cycle.
- phase_i  in  PHASE_W  signed phase sample.
- sync_i  in  1  restart: discards the previous sample, accumulator and count.
- dphase_o  out  PHASE_W  signed wrapped phase increment, same format as phase_i.
- dphase_valid_o  out  1  one-cycle strobe; dphase_o is new.
- freq_o  out  PHASE_W  signed mean increment over N samples; holds between updates.
- freq_valid_o  out  1  one-cycle strobe; freq_o is new.

## Operation
- PI is round(pi * 2^(PHASE_W-3)), and TWO_PI is 2*PI. For PHASE_W=10, PI=402 and TWO_PI=804.
- have_prev flag:
  - Cleared by rst and by sync_i.
  - A valid sample arriving while have_prev=0 only loads prev and sets have_prev; it produces no increment.
- Stage 1 (on valid with have_prev=1):
  - raw = phase_i - prev, computed at PHASE_W+1 bits.
  - Register raw, then load prev with phase_i.
- Stage 2 (wrap):
  - If raw > PI, d = raw - TWO_PI.
  - Else if raw < -PI, d = raw + TWO_PI.
  - Else d = raw.
  - Exactly ±PI is unchanged. d always fits PHASE_W bits and is registered to dphase_o.
- Stage 3 (average):
  - acc has width PHASE_W+AVG_LOG2 and cnt has width AVG_LOG2.
  - On each stage-2 output, sum = acc + d.
  - If cnt == N-1: freq_o is sum >>> AVG_LOG2 (arithmetic shift; truncation toward -inf), then acc = 0 and cnt = 0.
  - Otherwise: acc = sum and cnt = cnt+1.
- sync_i:
  - Clears have_prev, acc and cnt, and kills the stage-1 and stage-2 valid flags; those in-flight increments are dropped.
  - sync_i together with phase_valid_i: sync wins for history, and that sample becomes the new prev (have_prev=1).
- No backpressure: outputs are strobes, and downstream must accept every strobe.
- Reset values:
  - dphase_o = 0, dphase_valid_o = 0, freq_o = 0, freq_valid_o = 0.
  - acc, cnt, prev and have_prev are all 0.
- Reset mid-operation: all in-flight data is lost. The first valid sample after reset primes prev only.

## Timing
- Back-to-back phase_valid_i is allowed every cycle; throughput is 1 sample/clk.
- A valid sample captured at edge k gives dphase_valid_o high after edge k+2, for one cycle.
- For the N-th increment, freq_valid_o is high after edge k+3, for one cycle.
- freq_o changes only on the edge that raises freq_valid_o.
- sync_i takes effect at the edge where it is sampled. Strobes due after that edge do not occur.

## Configuration
- PHASE_FREQ_EST_ROUND_EN defined: the average is rounded half-up, freq_o = (sum + 2^(AVG_LOG2-1)) >>> AVG_LOG2.
- PHASE_FREQ_EST_ROUND_EN undefined: the average is truncated, as described above.
- Latency, width and the saturation-free range are identical in both builds.

## Structure
- Package phase_freq_pkg holds:
  - a function computing PI for a given PHASE_W;
  - a typedef for the PHASE_W+1-bit raw difference;
  - accumulator-width helpers.
- One sub-module, phase_wrap, implements the stage-2 compare/correct logic and its register. The top-level module instantiates it.

## Test plan
All tests use PHASE_W=10 and AVG_LOG2=2 (N=4).
- Constant step: phase 0, 50, 100, … every cycle.
  - Expected: no strobe for the first sample, then dphase_o=50 on each strobe.
  - Expected: freq_o=50 every 4th increment, at latency 2 for dphase and 3 for freq.
- Positive-to-negative wrap: prev=400, then -400.
  - Expected: dphase_o=4.
- Negative-to-positive wrap: prev=-400, then 400.
  - Expected: dphase_o=-4.
- Boundary: prev=0, then 402.
  - Expected: dphase_o=402, unchanged.
- Averaging with increments 1, 2, 3, 4 (sum 10):
  - Expected: freq_o=2 (truncated) or 3 (rounded).
- Averaging with increments summing to -10:
  - Expected: freq_o=-3 (truncated) or -2 (rounded).
- Sync and reset:
  - sync_i pulsed after 2 increments: the next freq_valid_o requires 4 fresh increments after a new prime sample.
  - sync_i together with valid: that sample becomes prev and no strobe is produced.
  - rst asserted mid-stream: all outputs are 0 immediately (asynchronous).

Source files
------------

// File: rtl/phase_freq_est_pkg.sv
// Shared constants and helpers for the phase-difference frequency estimator.
package phase_freq_pkg;

    localparam int DEF_PHASE_W  = 10;
    localparam int DEF_AVG_LOG2 = 2;

    // Raw phase difference carries one extra bit so phase_i - prev cannot overflow.
    typedef logic signed [DEF_PHASE_W:0] raw_t;

    // PI in the CORDIC atan format: 2 integer bits, PHASE_W-3 fraction bits.
    function automatic int piFor(input int phaseW);
        return $rtoi(3.14159265358979 * (2.0 ** (phaseW - 3)) + 0.5);
    endfunction

    // Accumulator must hold the sum of 2^avgLog2 signed increments.
    function automatic int accWidth(input int phaseW, input int avgLog2);
        return phaseW + avgLog2;
    endfunction

endpackage

// File: rtl/phase_freq_est_wrap.sv
// Stage-2 wrap: folds a raw phase difference back into [-PI, PI] and registers it.
module phase_wrap
    import phase_freq_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int PI      = piFor(DEF_PHASE_W)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      kill_i,
    input  logic                      valid_i,
    input  logic signed [PHASE_W:0]   raw_i,
    output logic signed [PHASE_W-1:0] d_o,
    output logic                      valid_o
);

    localparam logic signed [PHASE_W:0] PI_S     = (PHASE_W + 1)'(PI);
    localparam logic signed [PHASE_W:0] NEG_PI_S = (PHASE_W + 1)'(-PI);
    localparam logic [PHASE_W-1:0]      TWO_PI_W = PHASE_W'(2 * PI);

    logic signed [PHASE_W-1:0] d_d;
    logic signed [PHASE_W-1:0] d_q;
    logic                      valid_q;

    // Correct by one turn when outside +/-PI; the result always fits PHASE_W bits,
    // so the correction is done modulo 2^PHASE_W on the low bits only.
    always_comb begin
        d_d = raw_i[PHASE_W-1:0];
        if (raw_i > PI_S) begin
            d_d = raw_i[PHASE_W-1:0] - TWO_PI_W;
        end else if (raw_i < NEG_PI_S) begin
            d_d = raw_i[PHASE_W-1:0] + TWO_PI_W;
        end
    end

    // Output register; a restart drops the increment currently entering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_i && !kill_i;
            if (valid_i && !kill_i) begin
                d_q <= d_d;
            end
        end
    end

    assign d_o     = d_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/phase_freq_est.sv
// Phase-difference frequency estimator: wrapped per-sample phase increment plus
// a block average over 2^AVG_LOG2 increments.
// Build option: PHASE_FREQ_EST_ROUND_EN selects round-half-up averaging;
// left undefined the average truncates toward -inf.
module phase_freq_est
    import phase_freq_pkg::*;
#(
    parameter int PHASE_W  = DEF_PHASE_W,
    parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      phase_valid_i,
    input  logic signed [PHASE_W-1:0] phase_i,
    input  logic                      sync_i,
    output logic signed [PHASE_W-1:0] dphase_o,
    output logic                      dphase_valid_o,
    output logic signed [PHASE_W-1:0] freq_o,
    output logic                      freq_valid_o
);

    localparam int PI    = piFor(PHASE_W);
    localparam int ACC_W = accWidth(PHASE_W, AVG_LOG2);

    logic signed [PHASE_W-1:0] prev_q;
    logic                      havePrev_q;
    logic                      havePrev_d;
    logic                      take_d;
    logic signed [PHASE_W:0]   raw_d;
    logic signed [PHASE_W:0]   raw_q;
    logic                      rawValid_q;
    logic signed [PHASE_W:0]   rawDly_q;
    logic                      rawDlyValid_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [ACC_W-1:0]   sum_d;
    logic [AVG_LOG2-1:0]       cnt_q;
    logic signed [PHASE_W-1:0] avg_d;
    logic signed [PHASE_W-1:0] freq_q;
    logic                      freqValid_q;

    // Sample history: a difference is taken only when a previous sample exists
    // and no restart is requested; a restart with a sample re-primes history.
    always_comb begin
        take_d     = phase_valid_i && havePrev_q && !sync_i;
        raw_d      = {phase_i[PHASE_W-1], phase_i} - {prev_q[PHASE_W-1], prev_q};
        havePrev_d = havePrev_q;
        if (phase_valid_i) begin
            havePrev_d = 1'b1;
        end else if (sync_i) begin
            havePrev_d = 1'b0;
        end
    end

    // Stage 1 registers the raw difference, then an alignment register gives the
    // wrap stage its two-cycle position after capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q        <= '0;
            havePrev_q    <= 1'b0;
            raw_q         <= '0;
            rawValid_q    <= 1'b0;
            rawDly_q      <= '0;
            rawDlyValid_q <= 1'b0;
        end else begin
            havePrev_q    <= havePrev_d;
            rawValid_q    <= take_d;
            rawDlyValid_q <= rawValid_q && !sync_i;
            rawDly_q      <= raw_q;
            if (take_d) begin
                raw_q <= raw_d;
            end
            if (phase_valid_i) begin
                prev_q <= phase_i;
            end
        end
    end

    phase_wrap #(
        .PHASE_W (PHASE_W),
        .PI      (PI)
    ) u_wrap (
        .clk     (clk),
        .rst     (rst),
        .kill_i  (sync_i),
        .valid_i (rawDlyValid_q),
        .raw_i   (rawDly_q),
        .d_o     (dphase_o),
        .valid_o (dphase_valid_o)
    );

    // Running sum including the increment now on dphase_o, and its block mean.
    // Rounding adds half an LSB before the shift, which equals adding the bit
    // just below the kept field.
    always_comb begin
        sum_d = acc_q + {{AVG_LOG2{dphase_o[PHASE_W-1]}}, dphase_o};
`ifdef PHASE_FREQ_EST_ROUND_EN
        avg_d = sum_d[ACC_W-1:AVG_LOG2] + PHASE_W'(sum_d[AVG_LOG2-1]);
`else
        avg_d = sum_d[ACC_W-1:AVG_LOG2];
`endif
    end

    // Stage 3: accumulate increments and publish the mean every 2^AVG_LOG2 of them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            freq_q      <= '0;
            freqValid_q <= 1'b0;
        end else begin
            freqValid_q <= 1'b0;
            if (sync_i) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else if (dphase_valid_o) begin
                if (cnt_q == '1) begin
                    freq_q      <= avg_d;
                    freqValid_q <= 1'b1;
                    acc_q       <= '0;
                    cnt_q       <= '0;
                end else begin
                    acc_q <= sum_d;
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign freq_o       = freq_q;
    assign freq_valid_o = freqValid_q;

endmodule

// File: tb/tb_phase_freq_est.sv
// Self-checking bench for phase_freq_est (PHASE_W=10, AVG_LOG2=2).
module tb_phase_freq_est;

    localparam int PHASE_W  = 10;
    localparam int AVG_LOG2 = 2;
    localparam int N        = 4;
    localparam int PI       = 402;
    localparam int TWO_PI   = 804;

    typedef struct {
        int due;
        int val;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic                      phase_valid_i = 1'b0;
    logic signed [PHASE_W-1:0] phase_i = '0;
    logic                      sync_i = 1'b0;
    logic signed [PHASE_W-1:0] dphase_o;
    logic                      dphase_valid_o;
    logic signed [PHASE_W-1:0] freq_o;
    logic                      freq_valid_o;

    int   checkCount = 0;
    int   passCount  = 0;
    int   failCount  = 0;
    int   cyc        = 0;
    exp_t dphQ[$];
    exp_t frqQ[$];
    int   mPrev      = 0;
    bit   mHavePrev  = 1'b0;
    int   mAcc       = 0;
    int   mCnt       = 0;
    int   mLastFreq  = 0;

    phase_freq_est #(
        .PHASE_W  (PHASE_W),
        .AVG_LOG2 (AVG_LOG2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .phase_valid_i  (phase_valid_i),
        .phase_i        (phase_i),
        .sync_i         (sync_i),
        .dphase_o       (dphase_o),
        .dphase_valid_o (dphase_valid_o),
        .freq_o         (freq_o),
        .freq_valid_o   (freq_valid_o)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input integer observed, input integer expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int wrapModel(input int cur, input int prv);
        int r;
        r = cur - prv;
        if (r > PI) r = r - TWO_PI;
        else if (r < -PI) r = r + TWO_PI;
        return r;
    endfunction

    function automatic int avgModel(input int s);
`ifdef PHASE_FREQ_EST_ROUND_EN
        return (s + (1 << (AVG_LOG2 - 1))) >>> AVG_LOG2;
`else
        return s >>> AVG_LOG2;
`endif
    endfunction

    task automatic modelEdge(input bit v, input int p, input bit s);
        int d;
        if (s) begin
            while (dphQ.size() > 0 && dphQ[dphQ.size()-1].due >= cyc) void'(dphQ.pop_back());
            while (frqQ.size() > 0 && frqQ[frqQ.size()-1].due >= cyc) void'(frqQ.pop_back());
            mAcc      = 0;
            mCnt      = 0;
            mHavePrev = 1'b0;
        end
        if (v) begin
            if (mHavePrev) begin
                d = wrapModel(p, mPrev);
                dphQ.push_back('{cyc + 2, d});
                mAcc = mAcc + d;
                if (mCnt == N - 1) begin
                    frqQ.push_back('{cyc + 3, avgModel(mAcc)});
                    mAcc = 0;
                    mCnt = 0;
                end else begin
                    mCnt = mCnt + 1;
                end
            end
            mPrev     = p;
            mHavePrev = 1'b1;
        end
    endtask

    task automatic checkOutput();
        if (dphQ.size() > 0 && dphQ[0].due == cyc) begin
            checkValue("dphase_valid", dphase_valid_o, 1);
            checkValue("dphase", dphase_o, dphQ[0].val);
            void'(dphQ.pop_front());
        end else begin
            checkValue("dphase_idle", dphase_valid_o, 0);
        end
        if (frqQ.size() > 0 && frqQ[0].due == cyc) begin
            checkValue("freq_valid", freq_valid_o, 1);
            mLastFreq = frqQ[0].val;
            void'(frqQ.pop_front());
        end else begin
            checkValue("freq_idle", freq_valid_o, 0);
        end
        checkValue("freq_value", freq_o, mLastFreq);
    endtask

    task automatic applyStimulus(input bit v, input int p, input bit s);
        phase_valid_i = v;
        phase_i       = PHASE_W'(p);
        sync_i        = s;
        @(posedge clk);
        cyc++;
        modelEdge(v, p, s);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic doReset();
        rst = 1'b1;
        #1;
        checkValue("rst_dphase", dphase_o, 0);
        checkValue("rst_dphase_valid", dphase_valid_o, 0);
        checkValue("rst_freq", freq_o, 0);
        checkValue("rst_freq_valid", freq_valid_o, 0);
        dphQ.delete();
        frqQ.delete();
        mHavePrev     = 1'b0;
        mAcc          = 0;
        mCnt          = 0;
        mLastFreq     = 0;
        phase_valid_i = 1'b0;
        sync_i        = 1'b0;
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int p;
        bit v;
        bit s;

        doReset();

        // Constant step of 50 from -200 to 350.
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, -200 + 50 * i, 1'b0);
        repeat (4) applyStimulus(1'b0, 0, 1'b0);

        // Wraps and the +PI boundary: 400->-400, -400->400, 0->402.
        applyStimulus(1'b1, 400, 1'b1);
        applyStimulus(1'b1, -400, 1'b0);
        applyStimulus(1'b1, 400, 1'b0);
        applyStimulus(1'b1, 0, 1'b0);
        applyStimulus(1'b1, 402, 1'b0);
        repeat (4) applyStimulus(1'b0, 0, 1'b0);

        // Increments 1,2,3,4 (sum 10).
        applyStimulus(1'b1, 0, 1'b1);
        applyStimulus(1'b1, 1, 1'b0);
        applyStimulus(1'b1, 3, 1'b0);
        applyStimulus(1'b1, 6, 1'b0);
        applyStimulus(1'b1, 10, 1'b0);
        repeat (4) applyStimulus(1'b0, 0, 1'b0);

        // Increments summing to -10.
        applyStimulus(1'b1, 0, 1'b1);
        applyStimulus(1'b1, -1, 1'b0);
        applyStimulus(1'b1, -3, 1'b0);
        applyStimulus(1'b1, -6, 1'b0);
        applyStimulus(1'b1, -10, 1'b0);
        repeat (4) applyStimulus(1'b0, 0, 1'b0);

        // Restart after two increments, then four fresh increments after a prime.
        applyStimulus(1'b1, 0, 1'b1);
        applyStimulus(1'b1, 10, 1'b0);
        applyStimulus(1'b1, 20, 1'b0);
        repeat (3) applyStimulus(1'b0, 0, 1'b0);
        applyStimulus(1'b0, 0, 1'b1);
        applyStimulus(1'b1, 100, 1'b0);
        applyStimulus(1'b1, 110, 1'b0);
        applyStimulus(1'b1, 120, 1'b0);
        applyStimulus(1'b1, 130, 1'b0);
        applyStimulus(1'b1, 140, 1'b0);
        repeat (4) applyStimulus(1'b0, 0, 1'b0);

        // Restart while increments are still in flight drops them.
        applyStimulus(1'b1, 0, 1'b1);
        applyStimulus(1'b1, 10, 1'b0);
        applyStimulus(1'b1, 20, 1'b0);
        applyStimulus(1'b1, 30, 1'b0);
        applyStimulus(1'b0, 0, 1'b1);
        repeat (4) applyStimulus(1'b0, 0, 1'b0);

        // Random gapped traffic with occasional restarts.
        for (int i = 0; i < 60; i++) begin
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 19) == 0);
            p = int'($urandom_range(0, 804)) - 402;
            applyStimulus(v, p, s);
        end

        // Asynchronous reset mid-stream; first sample afterwards only primes.
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 20 * i, 1'b0);
        doReset();
        applyStimulus(1'b1, -50, 1'b0);
        applyStimulus(1'b1, -20, 1'b0);
        applyStimulus(1'b1, 10, 1'b0);
        applyStimulus(1'b1, 40, 1'b0);
        applyStimulus(1'b1, 70, 1'b0);
        repeat (6) applyStimulus(1'b0, 0, 1'b0);

        checkValue("dphase_queue_drained", dphQ.size(), 0);
        checkValue("freq_queue_drained", frqQ.size(), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
